// File: rtl/pc_ra_fetch.sv
// Instruction-fetch front end feeding pipeline stage 0.
// Holds a PC/RA register pair, with a flag selecting which register is the PC.
// Drives the fetch address, assembles 16-bit jump targets from the 8-bit data bus,
// and registers the fetched opcode byte onto the stage-0 pipe input.
module pc_ra_fetch #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              incPCRA0,
    input  logic              incPCRA1,
    input  logic              flip,
    input  logic              loadLo,
    input  logic              loadHi,
    input  logic [7:0]        dataBus,
    input  logic [7:0]        memData,
    input  logic              busRequest,
    input  logic              fetchSuppress,
    output logic [ADDR_W-1:0] fetchAddr,
    output logic              addrValid,
    output logic [7:0]        PipeIn,
    output logic              flag5_PCRA_flip,
    output logic [ADDR_W-1:0] raOut
);

    logic [ADDR_W-1:0] reg_a;
    logic [ADDR_W-1:0] reg_b;
    logic [ADDR_W-1:0] reg_a_next;
    logic [ADDR_W-1:0] reg_b_next;
    logic [ADDR_W-1:0] active_pc;
    logic [ADDR_W-1:0] stepped_pc;
    logic [ADDR_W-1:0] jump_target;
    logic [7:0]        low_latch;
    logic              inc;

    // Increment only when both stage-0 enables agree and the bus is ours.
    assign inc        = incPCRA0 & incPCRA1 & ~busRequest;
    assign active_pc  = flag5_PCRA_flip ? reg_b : reg_a;
    assign stepped_pc = inc ? active_pc + ADDR_W'(1) : active_pc;

    assign fetchAddr  = active_pc;
    assign raOut      = flag5_PCRA_flip ? reg_a : reg_b;
    assign addrValid  = ~busRequest;

    // Jump target: data bus as the high byte, latched low byte, middle bits zero.
    always_comb begin
        jump_target                 = '0;
        jump_target[7:0]            = low_latch;
        jump_target[ADDR_W-1 -: 8]  = dataBus;
    end

    // Next register values: the outgoing PC always takes its inc/hold value;
    // a load goes to whichever register is active after this edge's flip.
    always_comb begin
        reg_a_next = reg_a;
        reg_b_next = reg_b;
        if (!flag5_PCRA_flip) begin
            reg_a_next = stepped_pc;
            if (loadHi) begin
                if (flip) reg_b_next = jump_target;
                else      reg_a_next = jump_target;
            end
        end else begin
            reg_b_next = stepped_pc;
            if (loadHi) begin
                if (flip) reg_a_next = jump_target;
                else      reg_b_next = jump_target;
            end
        end
    end

    // PC/RA pair, role flag and jump-target low-byte latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_a           <= RESET_PC;
            reg_b           <= RESET_PC;
            low_latch       <= '0;
            flag5_PCRA_flip <= 1'b0;
        end else begin
            reg_a <= reg_a_next;
            reg_b <= reg_b_next;
            if (loadLo) low_latch <= dataBus;
            if (flip)   flag5_PCRA_flip <= ~flag5_PCRA_flip;
        end
    end

    // Opcode capture: memory byte when fetching, NOP bubble otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            PipeIn <= '0;
        end else if (!busRequest && !fetchSuppress) begin
            PipeIn <= memData;
        end else begin
            PipeIn <= '0;
        end
    end

endmodule

// File: tb/tb_pc_ra_fetch.sv
// Scoreboard bench for pc_ra_fetch: stimulus pushes the expected post-edge
// outputs, and a monitor pops and compares them one cycle later.
module tb_pc_ra_fetch;

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic [7:0]  pipe;
        logic        flag;
        logic [15:0] ra;
        logic        av;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        incPCRA0 = 1'b0;
    logic        incPCRA1 = 1'b0;
    logic        flip = 1'b0;
    logic        loadLo = 1'b0;
    logic        loadHi = 1'b0;
    logic [7:0]  dataBus = 8'h00;
    logic [7:0]  memData = 8'h00;
    logic        busRequest = 1'b0;
    logic        fetchSuppress = 1'b0;
    logic [15:0] fetchAddr;
    logic        addrValid;
    logic [7:0]  PipeIn;
    logic        flag5_PCRA_flip;
    logic [15:0] raOut;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    pc_ra_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset_n(reset_n),
        .incPCRA0(incPCRA0), .incPCRA1(incPCRA1),
        .flip(flip), .loadLo(loadLo), .loadHi(loadHi),
        .dataBus(dataBus), .memData(memData),
        .busRequest(busRequest), .fetchSuppress(fetchSuppress),
        .fetchAddr(fetchAddr), .addrValid(addrValid), .PipeIn(PipeIn),
        .flag5_PCRA_flip(flag5_PCRA_flip), .raOut(raOut)
    );

    always #5 clk = ~clk;

    task automatic check(input exp_t e);
        total++;
        if (fetchAddr !== e.addr || PipeIn !== e.pipe || flag5_PCRA_flip !== e.flag ||
            raOut !== e.ra || addrValid !== e.av) begin
            bad++;
            $display("FAIL %s: got addr=%h pipe=%h flag=%b ra=%h av=%b, want addr=%h pipe=%h flag=%b ra=%h av=%b",
                     e.name, fetchAddr, PipeIn, flag5_PCRA_flip, raOut, addrValid,
                     e.addr, e.pipe, e.flag, e.ra, e.av);
        end
    endtask

    function automatic exp_t mk(input string nm, input logic [15:0] a, input logic [7:0] p,
                                input logic f, input logic [15:0] r, input logic v);
        exp_t e;
        e.name = nm; e.addr = a; e.pipe = p; e.flag = f; e.ra = r; e.av = v;
        return e;
    endfunction

    // One clock: current inputs are applied, expected post-edge outputs are queued,
    // then one-cycle pulses are dropped at the next falling edge.
    task automatic cyc(input string nm, input logic [15:0] a, input logic [7:0] p,
                       input logic f, input logic [15:0] r, input logic v);
        sb.push_back(mk(nm, a, p, f, r, v));
        @(negedge clk);
        flip = 1'b0; loadLo = 1'b0; loadHi = 1'b0; fetchSuppress = 1'b0;
    endtask

    task automatic incs(input logic on);
        incPCRA0 = on; incPCRA1 = on;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e);
            end
        end
    end

    initial begin
        int waited;
        @(negedge clk);
        check(mk("reset_state", 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b1));
        reset_n = 1'b1;

        // Sequential fetch, PipeIn lags fetchAddr by one edge
        incs(1'b1);
        memData = 8'h11; cyc("seq1", 16'h0001, 8'h11, 1'b0, 16'h0000, 1'b1);
        memData = 8'h22; cyc("seq2", 16'h0002, 8'h22, 1'b0, 16'h0000, 1'b1);
        memData = 8'h33; cyc("seq3", 16'h0003, 8'h33, 1'b0, 16'h0000, 1'b1);
        memData = 8'h44; cyc("seq4", 16'h0004, 8'h44, 1'b0, 16'h0000, 1'b1);

        // Jump to FFFE and wrap through zero
        incs(1'b0); memData = 8'h00;
        loadLo = 1'b1; dataBus = 8'hFE; cyc("loadlo_fe", 16'h0004, 8'h00, 1'b0, 16'h0000, 1'b1);
        loadHi = 1'b1; dataBus = 8'hFF; cyc("loadhi_ff", 16'hFFFE, 8'h00, 1'b0, 16'h0000, 1'b1);
        incs(1'b1);
        cyc("inc_ffff", 16'hFFFF, 8'h00, 1'b0, 16'h0000, 1'b1);
        cyc("wrap_0000", 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b1);

        // Call to target with inc, then return
        incs(1'b0);
        loadLo = 1'b1; dataBus = 8'h34; cyc("loadlo_34", 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b1);
        loadHi = 1'b1; dataBus = 8'h12; cyc("pc_1234", 16'h1234, 8'h00, 1'b0, 16'h0000, 1'b1);
        loadLo = 1'b1; dataBus = 8'h00; cyc("loadlo_00", 16'h1234, 8'h00, 1'b0, 16'h0000, 1'b1);
        incs(1'b1); flip = 1'b1; loadHi = 1'b1; dataBus = 8'h80;
        cyc("call_8000", 16'h8000, 8'h00, 1'b1, 16'h1235, 1'b1);
        incs(1'b0); flip = 1'b1;
        cyc("return", 16'h1235, 8'h00, 1'b0, 16'h8000, 1'b1);

        // Bus request freezes the PC and inserts bubbles
        loadLo = 1'b1; dataBus = 8'h10; cyc("loadlo_10", 16'h1235, 8'h00, 1'b0, 16'h8000, 1'b1);
        loadHi = 1'b1; dataBus = 8'h00; cyc("pc_0010", 16'h0010, 8'h00, 1'b0, 16'h8000, 1'b1);
        incs(1'b1); busRequest = 1'b1; memData = 8'h77;
        cyc("busreq1", 16'h0010, 8'h00, 1'b0, 16'h8000, 1'b0);
        cyc("busreq2", 16'h0010, 8'h00, 1'b0, 16'h8000, 1'b0);
        cyc("busreq3", 16'h0010, 8'h00, 1'b0, 16'h8000, 1'b0);
        busRequest = 1'b0; memData = 8'h99;
        cyc("bus_release", 16'h0011, 8'h99, 1'b0, 16'h8000, 1'b1);

        // Fetch suppress gives a bubble but PC still advances
        fetchSuppress = 1'b1; memData = 8'hAA;
        cyc("suppress", 16'h0012, 8'h00, 1'b0, 16'h8000, 1'b1);
        cyc("unsuppress", 16'h0013, 8'hAA, 1'b0, 16'h8000, 1'b1);

        // Asynchronous reset between loadLo and loadHi clears the low latch
        incs(1'b0); memData = 8'h00;
        loadLo = 1'b1; dataBus = 8'h5A; cyc("loadlo_5a", 16'h0013, 8'h00, 1'b0, 16'h8000, 1'b1);
        #2 reset_n = 1'b0;
        #1 check(mk("async_reset", 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b1));
        @(negedge clk);
        reset_n = 1'b1;
        loadHi = 1'b1; dataBus = 8'h01; cyc("post_reset_hi", 16'h0100, 8'h00, 1'b0, 16'h0000, 1'b1);

        // loadLo and loadHi together use the old low byte
        loadLo = 1'b1; dataBus = 8'h22; cyc("loadlo_22", 16'h0100, 8'h00, 1'b0, 16'h0000, 1'b1);
        loadLo = 1'b1; loadHi = 1'b1; dataBus = 8'h33;
        cyc("lo_hi_same", 16'h3322, 8'h00, 1'b0, 16'h0000, 1'b1);
        loadHi = 1'b1; dataBus = 8'h44; cyc("hi_new_lo", 16'h4433, 8'h00, 1'b0, 16'h0000, 1'b1);

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_ra_fetch.md
Name: pc_ra_fetch

Overview:
- Instruction-fetch front end directly upstream of pipeline stage 0.
- Holds a register pair: program counter (PC) and return address (RA).
- Owns the PC/RA flip flag, drives the fetch address, and registers the fetched opcode byte onto stage 0's pipe input.
- Consumes stage 0's two increment enables and supports 16-bit jump loads assembled from the 8-bit data bus.

Parameters:
ADDR_W, 16, width of PC, RA and fetch address (even, >= 8)
RESET_PC, 0, value loaded into both registers at reset

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
incPCRA0  input  1  increment enable 0 from stage 0
incPCRA1  input  1  increment enable 1 from stage 0 (low during bus request)
flip  input  1  one-cycle pulse: swap roles of PC and RA (call/return)
loadLo  input  1  capture dataBus into jump-target low byte
loadHi  input  1  write {dataBus, low byte} into active PC
dataBus  input  8  internal data bus
memData  input  8  instruction memory read data for current fetchAddr
busRequest  input  1  external bus master owns memory
fetchSuppress  input  1  stage-0 suppress; blocks byte capture
fetchAddr  output  ADDR_W  address of next instruction byte (= active PC)
addrValid  output  1  fetchAddr driven to memory (= !busRequest)
PipeIn  output  8  registered opcode byte feeding stage 0
flag5_PCRA_flip  output  1  0: regA is PC; 1: regB is PC
raOut  output  ADDR_W  current return address (inactive register)

Behaviour:
- Reset (async, reset_n low): regA = regB = RESET_PC, lowLatch = 0, flag5_PCRA_flip = 0, PipeIn = 8'h00. All outputs are held while reset_n is low. Release takes effect at the first rising edge after reset_n rises.
- Active PC = flag ? regB : regA. RA = the other register. fetchAddr = active PC, combinational from the registers.
- inc = incPCRA0 & incPCRA1 & !busRequest.
- Priority per edge for the active PC: loadHi > inc > hold.
- Increment is modulo 2^ADDR_W: all-ones wraps to 0, with no carry flag.
- loadLo: lowLatch <= dataBus. lowLatch is the low 8 bits of the target; any middle bits (ADDR_W > 16) are zero.
- loadLo and loadHi in the same cycle: loadHi uses the new dataBus as the high byte and the OLD lowLatch as the low byte. lowLatch then updates.
- flip: flag <= !flag on the edge.
  - The register that was PC becomes RA.
  - If inc is asserted in the same cycle, the outgoing PC is incremented before becoming RA (call saves PC+1).
  - If loadHi is asserted in the same cycle, the load targets the newly active register (call to target). The outgoing PC keeps its increment or held value.
- Return sequence: flip alone. The old RA becomes PC and continues fetching.
- Fetch capture: on each edge, if !busRequest & !fetchSuppress then PipeIn <= memData, else PipeIn <= 8'h00 (NOP bubble). Latency is one cycle from fetchAddr to PipeIn.
- busRequest:
  - addrValid = 0.
  - No increment and no capture.
  - loadLo, loadHi and flip are still honoured.
  - Registers are otherwise frozen.
  - Deasserting busRequest resumes fetch at the unchanged PC.
- Reset asserted mid-load (after loadLo, before loadHi): lowLatch clears. A later loadHi uses low byte 0.
- raOut is never modified except by flip, loadHi-with-flip targeting, inc-with-flip, or reset.

Test Plan:
- Reset then 4 cycles with both incs high, memData = 8'h11, 22, 33, 44 → fetchAddr 0,1,2,3,4; PipeIn lags by one edge: 11, 22, 33, 44; flag = 0.
- Set PC = 16'hFFFE via loadLo (dataBus FE) then loadHi (dataBus FF); increment twice → fetchAddr FFFE, FFFF, 0000.
- PC = 16'h1234 with inc, flip and loadHi (dataBus 80, lowLatch 00) in one cycle → flag = 1, fetchAddr = 16'h8000, raOut = 16'h1235. Then flip alone → fetchAddr = 16'h1235, raOut = 16'h8000.
- busRequest high 3 cycles at PC = 16'h0010, incs high → fetchAddr stays 0010, addrValid = 0, PipeIn = 00. After release: 0011 on the next edge.
- fetchSuppress for 1 cycle with memData = AA → PipeIn = 00 for that cycle, and PC still increments.
- Assert reset_n low asynchronously mid-cycle after loadLo (dataBus 5A) → outputs clear immediately. After release, loadHi (dataBus 01) → fetchAddr = 16'h0100.
